arb_token_merge: RTL and testbench

ARB_TOKEN_MERGE -- requirements
Module: arb_token_merge

---
 rtl/arb_token_merge_pkg.sv | 13 +
 rtl/arb_burst_counter.sv | 28 ++
 rtl/arb_token_merge.sv | 111 +++++++++++
 tb/tb_arb_token_merge.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/arb_token_merge_pkg.sv
// Shared definitions for the two-requester burst merge: FSM states and sizing constants.
package arb_token_merge_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_burst_counter.sv
// Tokens-per-grant counter; terminal flags the position of the final token of a row.
module arb_burst_counter
    import arb_token_merge_pkg::*;
#(
    parameter int BURST_LEN = 512
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(BURST_LEN - 1);

    // clr wins over en so the final token of a row leaves the count at zero.
    always_ff @(posedge CLK) begin
        if (RESET || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == TERM_VAL);

endmodule

// File: rtl/arb_token_merge.sv
// Two-requester round-robin merge: a grant holds for a whole row of BURST_LEN
// tokens, with a one-cycle IDLE bubble between rows.
module arb_token_merge
    import arb_token_merge_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_LEN = 512
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] In0_DATA,
    input  logic              In0_SEND,
    input  logic [15:0]       In0_COUNT,
    output logic              In0_ACK,
    input  logic [DATA_W-1:0] In1_DATA,
    input  logic              In1_SEND,
    input  logic [15:0]       In1_COUNT,
    output logic              In1_ACK,
    output logic [DATA_W-1:0] Out_DATA,
    output logic              Out_SEND,
    output logic [15:0]       Out_COUNT,
    input  logic              Out_RDY,
    input  logic              Out_ACK,
    output logic              Out_LAST,
    output logic [1:0]        Grant
);

    // Handshake: a token moves when the granted SEND and Out_RDY are both high in
    // the same cycle; ACK and Out_SEND are that same-cycle strobe, never registered.

    arb_state_t        state, state_nx;
    logic              last_grant, last_grant_nx;
    logic              sel_send;
    logic [DATA_W-1:0] sel_data;
    logic              xfer;
    logic              terminal;
    logic [CNT_W-1:0]  burst_count;
    logic              unused_ok;

    assign unused_ok = ^{In0_COUNT, In1_COUNT, Out_ACK, burst_count};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
        end
    end

    assign sel_send = (state == ST_GRANT1) ? In1_SEND : In0_SEND;
    assign sel_data = (state == ST_GRANT1) ? In1_DATA : In0_DATA;
    assign xfer     = !RESET && (state != ST_IDLE) && sel_send && Out_RDY;

    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        case (state)
            ST_IDLE: begin
                // On a tie the requester that did not hold the previous row wins.
                if (In0_SEND && In1_SEND) begin
                    if (last_grant) begin
                        state_nx      = ST_GRANT0;
                        last_grant_nx = 1'b0;
                    end else begin
                        state_nx      = ST_GRANT1;
                        last_grant_nx = 1'b1;
                    end
                end else if (In0_SEND) begin
                    state_nx      = ST_GRANT0;
                    last_grant_nx = 1'b0;
                end else if (In1_SEND) begin
                    state_nx      = ST_GRANT1;
                    last_grant_nx = 1'b1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (xfer && terminal) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    arb_burst_counter #(
        .BURST_LEN (BURST_LEN)
    ) u_burst_counter (
        .CLK      (CLK),
        .RESET    (RESET),
        .en       (xfer),
        .clr      (xfer && terminal),
        .count    (burst_count),
        .terminal (terminal)
    );

    always_comb begin
        Out_SEND  = xfer;
        Out_DATA  = xfer ? sel_data : '0;
        Out_COUNT = {15'b0, xfer};
        Out_LAST  = xfer && terminal;
        In0_ACK   = xfer && (state == ST_GRANT0);
        In1_ACK   = xfer && (state == ST_GRANT1);
        Grant     = 2'b00;
        if (!RESET) begin
            Grant = {state == ST_GRANT1, state == ST_GRANT0};
        end
    end

endmodule

// File: tb/tb_arb_token_merge.sv
// Bench for arb_token_merge: a BURST_LEN=4 instance and a BURST_LEN=1 instance
// checked every cycle against a row-level reference model.
module tb_arb_token_merge;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [1:0]       rst, s0, s1, rdy, osend, olast, oack0, oack1;
    logic [1:0][15:0] d0, d1, od, ocount;
    logic [1:0][1:0]  ogrant;
    logic [15:0]      cnt_tie = 16'h00a5;
    logic             ack_tie = 1'b0;

    int bl[2] = '{4, 1};
    int m_owner[2], m_sent[2], m_last[2];
    int checks = 0, errors = 0;
    int tok_cnt = 0, last_cnt = 0, ack1_cnt = 0, last1_cnt = 0;
    logic [15:0] src_hist;

    arb_token_merge #(.DATA_W(16), .BURST_LEN(4)) dut4 (
        .CLK(CLK), .RESET(rst[0]),
        .In0_DATA(d0[0]), .In0_SEND(s0[0]), .In0_COUNT(cnt_tie), .In0_ACK(oack0[0]),
        .In1_DATA(d1[0]), .In1_SEND(s1[0]), .In1_COUNT(cnt_tie), .In1_ACK(oack1[0]),
        .Out_DATA(od[0]), .Out_SEND(osend[0]), .Out_COUNT(ocount[0]), .Out_RDY(rdy[0]),
        .Out_ACK(ack_tie), .Out_LAST(olast[0]), .Grant(ogrant[0])
    );

    arb_token_merge #(.DATA_W(16), .BURST_LEN(1)) dut1 (
        .CLK(CLK), .RESET(rst[1]),
        .In0_DATA(d0[1]), .In0_SEND(s0[1]), .In0_COUNT(cnt_tie), .In0_ACK(oack0[1]),
        .In1_DATA(d1[1]), .In1_SEND(s1[1]), .In1_COUNT(cnt_tie), .In1_ACK(oack1[1]),
        .Out_DATA(od[1]), .Out_SEND(osend[1]), .Out_COUNT(ocount[1]), .Out_RDY(rdy[1]),
        .Out_ACK(ack_tie), .Out_LAST(olast[1]), .Grant(ogrant[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs from the row-level view: who owns the output and how many tokens it has sent.
    task automatic check_dut(input int k);
        logic        xf, el, ea0, ea1;
        logic [15:0] ed;
        logic [1:0]  eg;
        string       p;
        p = $sformatf("bl%0d", bl[k]);
        xf = 1'b0; el = 1'b0; ea0 = 1'b0; ea1 = 1'b0; ed = '0; eg = 2'b00;
        if (!rst[k] && m_owner[k] >= 0) begin
            eg = (m_owner[k] == 0) ? 2'b01 : 2'b10;
            xf = rdy[k] && ((m_owner[k] == 0) ? s0[k] : s1[k]);
            if (xf) begin
                ed  = (m_owner[k] == 0) ? d0[k] : d1[k];
                el  = (m_sent[k] + 1 == bl[k]);
                ea0 = (m_owner[k] == 0);
                ea1 = (m_owner[k] == 1);
            end
        end
        chk({p, " grant"}, 32'(ogrant[k]), 32'(eg));
        chk({p, " out_send"}, 32'(osend[k]), 32'(xf));
        chk({p, " out_data"}, 32'(od[k]), 32'(ed));
        chk({p, " out_count"}, 32'(ocount[k]), xf ? 32'd1 : 32'd0);
        chk({p, " out_last"}, 32'(olast[k]), 32'(el));
        chk({p, " ack0"}, 32'(oack0[k]), 32'(ea0));
        chk({p, " ack1"}, 32'(oack1[k]), 32'(ea1));
    endtask

    task automatic model_advance(input int k);
        if (rst[k]) begin
            m_owner[k] = -1;
            m_sent[k]  = 0;
            m_last[k]  = 1;
        end else if (m_owner[k] < 0) begin
            if (s0[k] && s1[k]) m_owner[k] = 1 - m_last[k];
            else if (s0[k])     m_owner[k] = 0;
            else if (s1[k])     m_owner[k] = 1;
            if (m_owner[k] >= 0) m_last[k] = m_owner[k];
        end else if (rdy[k] && ((m_owner[k] == 0) ? s0[k] : s1[k])) begin
            m_sent[k]++;
            if (m_sent[k] == bl[k]) begin
                m_sent[k]  = 0;
                m_owner[k] = -1;
            end
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1ns later.
    task automatic tick();
        for (int k = 0; k < 2; k++) begin
            d0[k] = 16'($urandom);
            d1[k] = 16'($urandom);
        end
        #1;
        for (int k = 0; k < 2; k++) check_dut(k);
        tok_cnt   += int'(osend[0]);
        last_cnt  += int'(olast[0]);
        ack1_cnt  += int'(oack1[0]);
        last1_cnt += int'(olast[1]);
        src_hist   = {src_hist[13:0], oack1[1], oack0[1]};
        for (int k = 0; k < 2; k++) model_advance(k);
        @(negedge CLK);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_sent[k] = 0; m_last[k] = 1;
        end
        rst = 2'b11; s0 = 2'b00; s1 = 2'b00; rdy = 2'b00;
        d0 = '0; d1 = '0; src_hist = '0;
        @(negedge CLK);
        tick(); tick();
        chk("reset grant", 32'(ogrant[0]), 32'd0);

        // Single requester with permanent ready: row, bubble, regrant.
        rst[0] = 1'b0; s0[0] = 1'b1; rdy[0] = 1'b1; tok_cnt = 0; last_cnt = 0;
        repeat (8) tick();
        chk("single tokens", 32'(tok_cnt), 32'd6);
        chk("single last", 32'(last_cnt), 32'd1);

        // Tie after reset: In0 first, then strict alternation by whole rows.
        rst[0] = 1'b1; tick(); rst[0] = 1'b0;
        s0[0] = 1'b1; s1[0] = 1'b1; tok_cnt = 0; ack1_cnt = 0;
        repeat (20) tick();
        chk("tie tokens", 32'(tok_cnt), 32'd16);
        chk("tie in1 tokens", 32'(ack1_cnt), 32'd8);

        // Backpressure for 3 cycles after the second token.
        rst[0] = 1'b1; s0[0] = 1'b0; s1[0] = 1'b0; tick(); rst[0] = 1'b0;
        tok_cnt = 0; last_cnt = 0;
        for (int i = 0; i < 13; i++) begin
            rdy[0] = !(i >= 3 && i <= 5);
            s0[0]  = (i < 8);
            tick();
        end
        chk("bp tokens", 32'(tok_cnt), 32'd4);
        chk("bp last", 32'(last_cnt), 32'd1);

        // Granted requester stalls while the other waits.
        rst[0] = 1'b1; tick(); rst[0] = 1'b0;
        s0[0] = 1'b1; s1[0] = 1'b0; rdy[0] = 1'b1;
        repeat (2) tick();
        s0[0] = 1'b0; s1[0] = 1'b1; ack1_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall grant", 32'(ogrant[0]), 32'd1);
        end
        chk("stall ack1", 32'(ack1_cnt), 32'd0);
        s0[0] = 1'b1;
        repeat (12) tick();

        // Reset after 2 of 4 tokens; next row starts from zero.
        rst[0] = 1'b1; tick(); rst[0] = 1'b0;
        s0[0] = 1'b1; s1[0] = 1'b0; rdy[0] = 1'b1;
        repeat (3) tick();
        rst[0] = 1'b1; tick();
        chk("post-reset grant", 32'(ogrant[0]), 32'd0);
        rst[0] = 1'b0; tok_cnt = 0; last_cnt = 0;
        repeat (6) tick();
        chk("rerow tokens", 32'(tok_cnt), 32'd4);
        chk("rerow last", 32'(last_cnt), 32'd1);

        // Single-token rows: In0, bubble, In1, bubble, ...
        s0[0] = 1'b0;
        rst[1] = 1'b0; s0[1] = 1'b1; s1[1] = 1'b1; rdy[1] = 1'b1;
        src_hist = '0; last1_cnt = 0;
        repeat (8) tick();
        chk("bl1 sources", 32'(src_hist), 32'h1212);
        chk("bl1 last", 32'(last1_cnt), 32'd4);

        // Random traffic on both instances.
        rst = 2'b11; tick(); rst = 2'b00;
        repeat (300) begin
            s0  = 2'($urandom);
            s1  = 2'($urandom);
            rdy = 2'($urandom) | 2'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
